alu_serial_ctrl: RTL
====================

Name: alu_serial_ctrl

Overview:
Bit-serial sequencer that drives the team's combinational 1-bit ALU slice (alu_1bit) from the initiator side.
- Latches two WIDTH-bit operands and a 4-bit aluop.
- Presents one bit pair, carry and aluop to the slice per cycle, LSB first, and collects the slice's result and carry-out.
- Assembles a WIDTH-bit result with a done handshake; the slice is instantiated beside it at the next level up.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE or DONE
a_in  input  WIDTH  operand A, latched on accepted start
b_in  input  WIDTH  operand B, latched on accepted start
op  input  4  aluop: [3] invert A, [2] invert B, [1:0] 00 AND / 01 OR / 10 ADD
slice_a  output  1  current A bit to slice
slice_b  output  1  current B bit to slice
slice_cin  output  1  carry into slice
slice_aluop  output  4  latched op to slice
slice_result  input  1  slice result bit (combinational from slice_* outputs)
slice_cout  input  1  slice carry-out
busy  output  1  high in RUN
done  output  1  one-cycle pulse, result valid
result  output  WIDTH  assembled result, held until next accepted start
cout  output  1  final carry-out (carry out of bit WIDTH-1)
zero  output  1  result == 0
overflow  output  1  signed overflow (see Optional Feature)

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset values: state=IDLE; busy=0, done=0, result=0, cout=0, zero=1, overflow=0; bit index=0; carry register=0; slice_* outputs=0.
- States: IDLE, RUN, DONE.
- IDLE: start=1 at an edge latches a_in, b_in and op, clears index and result, sets carry=op[2], and enters RUN. start=0 stays in IDLE.
- RUN, per cycle with index i:
  - slice_a=A[i], slice_b=B[i], slice_cin=carry, slice_aluop=latched op.
  - At the edge: result[i]<=slice_result, carry<=slice_cout, i<=i+1.
  - When i==WIDTH-1: capture the final bit, set cout<=slice_cout, and enter DONE.
- Initial carry: carry=op[2] means op=0110 gives A-B (A+~B+1). AND/OR ops ignore the carry chain, but it is still recorded into cout.
- DONE (one cycle):
  - done=1; zero reflects the final result.
  - start=1 here is accepted exactly as in IDLE (back-to-back, goes straight to RUN).
  - Otherwise return to IDLE.
- Latency: accepted start at edge E0 gives RUN for WIDTH cycles; done is high during the cycle following edge E(WIDTH). Throughput is one operation per WIDTH+1 cycles.
- start during RUN is ignored; latched operands are not disturbed.
- op[1:0]=11 is not rejected: the slice returns 0 per bit, so result=0 and zero=1.
- result, cout, zero and overflow hold their values from DONE through IDLE until the next accepted start clears result.
- slice_* outputs are 0 outside RUN.
- rst asserted mid-RUN aborts immediately to reset values; no done pulse is issued.

Optional Feature:
OVERFLOW_DETECT_EN.
- Defined: on the last RUN bit, overflow<=slice_cin XOR slice_cout, valid only when op[1:0]=10, else 0. It is cleared on accepted start.
- Undefined: the overflow port still exists, tied to constant 0, with no extra logic.

Test Plan:
- WIDTH=8, a=0x35, b=0x4A, op=0010, start one cycle -> busy for 8 cycles, done pulse on 9th cycle after start edge, result=0x7F, cout=0, zero=0.
- a=0x10, b=0x01, op=0110 (subtract) -> result=0x0F, cout=1.
- a=0xF0, b=0x3C, op=0000 (AND) -> result=0x30; then op=1101 (NOT A OR NOT B = NAND) with a=0xFF, b=0xFF -> result=0x00, zero=1.
- With OVERFLOW_DETECT_EN: a=0x7F, b=0x01, op=0010 -> result=0x80, overflow=1, cout=0. Without the macro -> overflow=0.
- Pulse start again at cycle 3 of RUN with different operands -> ignored, original result delivered. start held high through DONE -> new operation begins with no idle cycle.
- Assert rst at RUN cycle 4 -> all outputs at reset values immediately, no done. Next start completes normally.

Source files
------------

// File: rtl/alu_serial_ctrl_if.sv
// Request/response bundle between an initiator and the serial ALU sequencer.
interface alu_serial_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [3:0]       op;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             zero;
    logic             overflow;

    modport master (
        output start, a_in, b_in, op,
        input  busy, done, result, cout, zero, overflow
    );

    modport slave (
        input  start, a_in, b_in, op,
        output busy, done, result, cout, zero, overflow
    );
endinterface

// File: rtl/alu_serial_ctrl.sv
// Bit-serial sequencer driving an external 1-bit ALU slice, LSB first.
// Define OVERFLOW_DETECT_EN to register signed overflow for ADD ops.
module alu_serial_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    alu_serial_ctrl_if.slave    bus,
    output logic                slice_a,
    output logic                slice_b,
    output logic                slice_cin,
    output logic [3:0]          slice_aluop,
    input  logic                slice_result,
    input  logic                slice_cout
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [3:0]       op_reg;
    logic [IW-1:0]    idx;
    logic             carry;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] res_next;
    logic             busy;
    logic             done;
    logic             cout;
    logic             zero;
`ifdef OVERFLOW_DETECT_EN
    logic             overflow;
`endif

    always_comb begin
        res_next      = result;
        res_next[idx] = slice_result;
    end

    // Slice inputs are only meaningful while a bit is being processed.
    always_comb begin
        slice_a     = 1'b0;
        slice_b     = 1'b0;
        slice_cin   = 1'b0;
        slice_aluop = '0;
        if (state == RUN) begin
            slice_a     = a_reg[idx];
            slice_b     = b_reg[idx];
            slice_cin   = carry;
            slice_aluop = op_reg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            a_reg    <= '0;
            b_reg    <= '0;
            op_reg   <= '0;
            idx      <= '0;
            carry    <= 1'b0;
            result   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            cout     <= 1'b0;
            zero     <= 1'b1;
`ifdef OVERFLOW_DETECT_EN
            overflow <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (bus.start) begin
                        a_reg  <= bus.a_in;
                        b_reg  <= bus.b_in;
                        op_reg <= bus.op;
                        idx    <= '0;
                        result <= '0;
                        // Seeding carry with invert-B turns A + ~B into A - B.
                        carry  <= bus.op[2];
                        busy   <= 1'b1;
                        state  <= RUN;
`ifdef OVERFLOW_DETECT_EN
                        overflow <= 1'b0;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    result[idx] <= slice_result;
                    carry       <= slice_cout;
                    if (idx == LAST) begin
                        idx   <= '0;
                        cout  <= slice_cout;
                        zero  <= (res_next == '0);
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
`ifdef OVERFLOW_DETECT_EN
                        overflow <= (op_reg[1:0] == 2'b10) ? (carry ^ slice_cout) : 1'b0;
`endif
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy   = busy;
    assign bus.done   = done;
    assign bus.result = result;
    assign bus.cout   = cout;
    assign bus.zero   = zero;
`ifdef OVERFLOW_DETECT_EN
    assign bus.overflow = overflow;
`else
    assign bus.overflow = 1'b0;
`endif
endmodule
